// File: rtl/sram_rw_init_ext_if.sv
// sram_rw_init_ext_if: single read/write port bundle for the self-clearing SRAM wrapper
interface sram_rw_init_ext_if #(
    parameter int ADDR_W   = 7,
    parameter int WIDTH    = 5,
    parameter int MASK_SEG = 1
);
    logic [ADDR_W-1:0]   RW0_addr;
    logic                RW0_en;
    logic                RW0_wmode;
    logic [MASK_SEG-1:0] RW0_wmask;
    logic [WIDTH-1:0]    RW0_wdata;
    logic [WIDTH-1:0]    RW0_rdata;
    logic                RW0_rvalid;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_rdata, RW0_rvalid
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_rdata, RW0_rvalid
    );
endinterface

// File: rtl/sram_rw_init_ext.sv
// sram_rw_init_ext: single-port masked RAM with 1-cycle registered read and a hardware clear engine
module sram_rw_init_ext #(
    parameter int                DEPTH    = 128,
    parameter int                WIDTH    = 5,
    parameter int                MASK_SEG = 1,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    sram_rw_init_ext_if.slave    rw,
    input  logic                 init_req,
    output logic                 ready
);
    localparam int              G       = WIDTH / MASK_SEG;
    localparam logic [0:0]      S_CLEAR = 1'b0;
    localparam logic [0:0]      S_READY = 1'b1;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              in_range;
    logic              acc;
    logic              wr;
    logic              rd;
    logic              clr_we;

    // Addresses past DEPTH never touch the array; reads of them return INIT_VAL.
    assign in_range = {1'b0, rw.RW0_addr} < DEPTH_W;
    assign ready    = state == S_READY;
    assign acc      = rw.RW0_en && ready && !reset;
    assign wr       = acc && rw.RW0_wmode && in_range;
    assign rd       = acc && !rw.RW0_wmode;
    assign clr_we   = state == S_CLEAR && !reset;

    // Clear sequencer: walk every entry once, then open the port; init_req restarts it from READY only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else if (state == S_CLEAR) begin
            state <= ptr == LAST ? S_READY : S_CLEAR;
            ptr   <= ptr == LAST ? '0 : ptr + ADDR_W'(1);
        end else if (init_req) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end
    end

    // Array write: clear overrides the port with a full-width INIT_VAL, otherwise masked segment writes.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[ptr] <= INIT_VAL;
        end else if (wr) begin
            for (int i = 0; i < MASK_SEG; i++)
                if (rw.RW0_wmask[i])
                    mem[rw.RW0_addr][i*G +: G] <= rw.RW0_wdata[i*G +: G];
        end
    end

    // Read data is captured only on an accepted read and held otherwise; rvalid marks the update cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rw.RW0_rdata  <= '0;
            rw.RW0_rvalid <= 1'b0;
        end else begin
            rw.RW0_rvalid <= rd;
            if (rd)
                rw.RW0_rdata <= in_range ? mem[rw.RW0_addr] : INIT_VAL;
        end
    end
endmodule

// File: tb/tb_sram_rw_init_ext.sv
// tb_sram_rw_init_ext: scoreboard bench for the self-clearing single-port SRAM wrapper
module tb_sram_rw_init_ext;
    localparam int DEPTH    = 128;
    localparam int WIDTH    = 16;
    localparam int MASK_SEG = 2;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int G        = WIDTH / MASK_SEG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_req = 1'b0;
    logic ready;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_v;

    always #5 clk = ~clk;

    sram_rw_init_ext_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG)) bus ();

    sram_rw_init_ext #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_SEG(MASK_SEG), .INIT_VAL(16'h0000)
    ) dut (
        .clock(clk),
        .reset(rst),
        .rw(bus),
        .init_req(init_req),
        .ready(ready)
    );

    // Scoreboard: every rvalid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (bus.RW0_rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: rdata=%h with no read outstanding", bus.RW0_rdata);
            end else begin
                exp_v = exp_q.pop_front();
                if (bus.RW0_rdata !== exp_v) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", bus.RW0_rdata, exp_v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic idle();
        bus.RW0_en    = 1'b0;
        bus.RW0_wmode = 1'b0;
        bus.RW0_wmask = '0;
        bus.RW0_wdata = '0;
        bus.RW0_addr  = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [MASK_SEG-1:0] m);
        bus.RW0_en    = 1'b1;
        bus.RW0_wmode = 1'b1;
        bus.RW0_addr  = ADDR_W'(a);
        bus.RW0_wdata = d;
        bus.RW0_wmask = m;
        for (int i = 0; i < MASK_SEG; i++)
            if (m[i]) model[a][i*G +: G] = d[i*G +: G];
        @(negedge clk);
        idle();
    endtask

    task automatic do_read(input int a);
        bus.RW0_en    = 1'b1;
        bus.RW0_wmode = 1'b0;
        bus.RW0_addr  = ADDR_W'(a);
        exp_q.push_back(model[a]);
        @(negedge clk);
        idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b0 || bus.RW0_rvalid !== 1'b0 || bus.RW0_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rvalid=%b rdata=%h expected 0/0/0000",
                     ready, bus.RW0_rvalid, bus.RW0_rdata);
        end
        rst = 1'b0;
        wait_ready(n);
        clear_model();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_length: ready low %0d cycles expected %0d", n, DEPTH);
        end
    endtask

    task automatic test_reads_after_clear();
        do_read(0);
        do_read(63);
        do_read(127);
        @(negedge clk);
        checks++;
        if (bus.RW0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_single: rvalid=%b expected 0", bus.RW0_rvalid);
        end
    endtask

    task automatic test_clear_ignore();
        int n;
        bit bad;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                bus.RW0_en = 1'b1; bus.RW0_wmode = 1'b1; bus.RW0_addr = ADDR_W'(3);
                bus.RW0_wdata = 16'h001F; bus.RW0_wmask = 2'b11;
            end else if (c == 11) begin
                bus.RW0_en = 1'b1; bus.RW0_wmode = 1'b0; bus.RW0_addr = ADDR_W'(3);
            end else begin
                idle();
            end
            @(negedge clk);
            if (bus.RW0_rvalid !== 1'b0) bad = 1'b1;
        end
        idle();
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL clear_no_rvalid: rvalid=1 seen during clear expected 0");
        end
        wait_ready(n);
        checks++;
        if (n != DEPTH - 20) begin
            errors++;
            $display("FAIL clear_ignore_length: ready low %0d more cycles expected %0d", n, DEPTH - 20);
        end
        clear_model();
        do_read(3);
    endtask

    task automatic test_mask();
        do_write(5, 16'hABCD, 2'b11);
        do_write(5, 16'h1234, 2'b01);
        do_read(5);
        do_write(5, 16'h0000, 2'b00);
        checks++;
        if (bus.RW0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask_rvalid: rvalid=%b expected 0", bus.RW0_rvalid);
        end
        do_read(5);
        @(negedge clk);
    endtask

    task automatic test_hold();
        do_read(5);
        do_write(5, 16'hFFFF, 2'b11);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus.RW0_rvalid !== 1'b0 || bus.RW0_rdata !== 16'hAB34) begin
                errors++;
                $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 0/ab34", bus.RW0_rvalid, bus.RW0_rdata);
            end
            @(negedge clk);
        end
        do_read(5);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit bad;
        for (int i = 0; i < 4; i++) do_write(20 + i, 16'h1111 * (i + 1), 2'b11);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.RW0_en = 1'b1; bus.RW0_wmode = 1'b0; bus.RW0_addr = ADDR_W'(20 + i);
            exp_q.push_back(model[20 + i]);
            @(negedge clk);
            if (bus.RW0_rvalid !== 1'b1) bad = 1'b1;
        end
        idle();
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL back_to_back_rvalid: rvalid dropped expected continuous 1");
        end
        @(negedge clk);
        checks++;
        if (bus.RW0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: rvalid=%b expected 0", bus.RW0_rvalid);
        end
    endtask

    task automatic test_init_req();
        int n;
        do_read(5);
        bus.RW0_en = 1'b1; bus.RW0_wmode = 1'b1; bus.RW0_addr = ADDR_W'(9);
        bus.RW0_wdata = 16'h001F; bus.RW0_wmask = 2'b11;
        init_req = 1'b1;
        @(negedge clk);
        idle();
        init_req = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL init_req_ready: ready=%b expected 0", ready);
        end
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_req_length: ready low %0d cycles expected %0d", n, DEPTH);
        end
        checks++;
        if (bus.RW0_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL rdata_persist: rdata=%h expected ffff", bus.RW0_rdata);
        end
        clear_model();
        do_read(9);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        do_write(7, 16'h5A5A, 2'b11);
        do_read(7);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.RW0_rdata !== 16'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear_reset: rdata=%h ready=%b expected 0000/0", bus.RW0_rdata, ready);
        end
        wait_ready(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_clear_length: ready low %0d cycles expected %0d", n, DEPTH);
        end
        clear_model();
        do_read(7);
        do_read(127);
        @(negedge clk);
    endtask

    initial begin
        idle();
        clear_model();
        @(negedge clk);
        test_reset();
        test_reads_after_clear();
        test_clear_ignore();
        test_mask();
        test_hold();
        test_back_to_back();
        test_init_req();
        test_reset_mid_clear();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding_reads: %0d reads never returned expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
